// File: rtl/io_display_ctrl.sv
// io_display_ctrl: MIPS IO-bus peripheral driving multiplexed 7-seg digits and reading switches.
// Per-digit blinking is compiled in when IO_DISPLAY_BLINK_EN is defined.
module io_display_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SEG_W        = 7,
   parameter int REFRESH_BITS = 14,
   parameter int SW_W         = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [3:0]            IOAddr,
   input  logic [31:0]           IOWriteData,
   input  logic                  IOWriteEn,
   output logic [31:0]           IOReadData,
   input  logic [SW_W-1:0]       SW,
   output logic [SEG_W-1:0]      LED,
   output logic [NUM_DIGITS-1:0] AN
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

   localparam logic [3:0] A_LO   = 4'h0;
   localparam logic [3:0] A_HI   = 4'h1;
   localparam logic [3:0] A_CTRL = 4'h2;
   localparam logic [3:0] A_SW   = 4'h4;
   localparam logic [3:0] A_STAT = 4'h5;

   logic [SEG_W-1:0]        dig_q [NUM_DIGITS];
   logic [SEG_W-1:0]        dig_d [NUM_DIGITS];
   logic                    en_q, en_d;
   logic [7:0]              blank_q, blank_d;
   logic [REFRESH_BITS-1:0] pre_q, pre_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [SW_W-1:0]         s1_q, s2_q, s3_q;
   logic                    chg_q, chg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [SEG_W-1:0]        led_q, led_d;

   logic                    wr_lo, wr_hi, wr_ctrl, wr_stat;
   logic                    pre_wrap, scan_wrap;
   logic [SEG_W-1:0]        cur_dig;
   logic                    cur_blank;
   logic                    blink_off;
   logic                    lit;
   logic [31:0]             rdata;
   logic                    unused_wdata;

`ifdef IO_DISPLAY_BLINK_EN
   logic [7:0]              blink_q, blink_d;
   logic [7:0]              bcnt_q, bcnt_d;
   logic                    cur_blink;
`endif

   assign unused_wdata = ^IOWriteData;

   assign wr_lo   = IOWriteEn && (IOAddr == A_LO);
   assign wr_hi   = IOWriteEn && (IOAddr == A_HI);
   assign wr_ctrl = IOWriteEn && (IOAddr == A_CTRL);
   assign wr_stat = IOWriteEn && (IOAddr == A_STAT);

   assign pre_wrap  = &pre_q;
   assign scan_wrap = pre_wrap && (idx_q == LAST);

   // Register file and scan next-state
   always_comb begin
      dig_d   = dig_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((i < 4) ? wr_lo : wr_hi) begin
            dig_d[i] = IOWriteData[(i % 4) * SEG_W +: SEG_W];
         end
      end
      en_d    = wr_ctrl ? IOWriteData[0]    : en_q;
      blank_d = wr_ctrl ? IOWriteData[15:8] : blank_q;
      pre_d   = pre_q + 1'b1;
      idx_d   = idx_q;
      if (pre_wrap) begin
         idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
      end
      if (s2_q != s3_q) begin
         chg_d = 1'b1;
      end else if (wr_stat && IOWriteData[0]) begin
         chg_d = 1'b0;
      end else begin
         chg_d = chg_q;
      end
   end

`ifdef IO_DISPLAY_BLINK_EN
   always_comb begin
      blink_d = wr_ctrl ? IOWriteData[23:16] : blink_q;
      bcnt_d  = bcnt_q + {7'd0, scan_wrap};
   end
`endif

   // Select the digit currently being scanned
   always_comb begin
      cur_dig   = '0;
      cur_blank = 1'b0;
`ifdef IO_DISPLAY_BLINK_EN
      cur_blink = 1'b0;
`endif
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_dig   = dig_q[i];
            cur_blank = blank_q[i];
`ifdef IO_DISPLAY_BLINK_EN
            cur_blink = blink_q[i];
`endif
         end
      end
   end

`ifdef IO_DISPLAY_BLINK_EN
   assign blink_off = cur_blink && bcnt_q[7];
`else
   assign blink_off = 1'b0;
`endif

   assign lit = en_q && !cur_blank && !blink_off;

   always_comb begin
      an_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (lit && (idx_q == IDX_W'(i))) begin
            an_d[i] = 1'b0;
         end
      end
      led_d = lit ? ~cur_dig : '1;
   end

   // Bus read mux, no side effects
   always_comb begin
      rdata = '0;
      case (IOAddr)
         A_LO: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (i < 4) begin
                  rdata[(i % 4) * SEG_W +: SEG_W] = dig_q[i];
               end
            end
         end
         A_HI: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (i >= 4) begin
                  rdata[(i % 4) * SEG_W +: SEG_W] = dig_q[i];
               end
            end
         end
         A_CTRL: begin
            rdata[0]    = en_q;
            rdata[15:8] = blank_q;
`ifdef IO_DISPLAY_BLINK_EN
            rdata[23:16] = blink_q;
`endif
         end
         A_SW:    rdata[SW_W-1:0] = s2_q;
         A_STAT:  rdata[0] = chg_q;
         default: rdata = '0;
      endcase
   end

   assign IOReadData = rdata;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_q[i] <= '0;
         end
         en_q    <= 1'b1;
         blank_q <= '0;
         pre_q   <= '0;
         idx_q   <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         chg_q   <= 1'b0;
         an_q    <= ~NUM_DIGITS'(1);
         led_q   <= '1;
      end else begin
         dig_q   <= dig_d;
         en_q    <= en_d;
         blank_q <= blank_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         s1_q    <= SW;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         chg_q   <= chg_d;
         an_q    <= an_d;
         led_q   <= led_d;
      end
   end

`ifdef IO_DISPLAY_BLINK_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         blink_q <= '0;
         bcnt_q  <= '0;
      end else begin
         blink_q <= blink_d;
         bcnt_q  <= bcnt_d;
      end
   end
`endif

   assign AN  = an_q;
   assign LED = led_q;

endmodule
